// File: rtl/register_file_mp_pkg.sv
// Shared defaults for the multi-port register file and its bench.
// Widths, depth and port counts live here so both sides agree.
package register_file_mp_pkg;
  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_N_WR     = 2;
  localparam int RF_N_RD     = 2;
  localparam int RF_ZERO_REG = 1;
  localparam int RF_BYPASS   = 1;
  localparam int RF_DEPTH    = 2 ** RF_ADDR_W;
endpackage

// File: rtl/register_file_mp_rf_scoreboard.sv
// Pending-bit scoreboard: per-register reservation bits, rsv_ok and rd_busy.
// Latency: rsv_ok/rd_busy combinational, pending bits update on the clk edge; no backpressure.
module rf_scoreboard #(
  parameter int ADDR_W   = 5,
  parameter int N_WR     = 2,
  parameter int N_RD     = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic [N_WR-1:0]        wr_act,
  input  logic [N_WR*ADDR_W-1:0] wr_index,
  input  logic                   rsv_en,
  input  logic [ADDR_W-1:0]      rsv_index,
  input  logic [N_RD*ADDR_W-1:0] rd_index,
  output logic                   rsv_ok,
  output logic [N_RD-1:0]        rd_busy
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] pending;
  logic [DEPTH-1:0] wr_mask;
  logic [DEPTH-1:0] set_mask;
  logic             rsv_zero;
  logic             rsv_set;

  // wr_act is already gated by clr and by the hard-wired zero register
  always_comb begin
    wr_mask = '0;
    for (int p = 0; p < N_WR; p++)
      if (wr_act[p]) wr_mask[wr_index[p*ADDR_W +: ADDR_W]] = 1'b1;
  end

  assign rsv_zero = (ZERO_REG != 0) && (rsv_index == '0);
  assign rsv_ok   = rsv_en && (rsv_zero || !pending[rsv_index] || wr_mask[rsv_index]);
  assign rsv_set  = rsv_ok && !clr && !rsv_zero;

  always_comb begin
    set_mask = '0;
    if (rsv_set) set_mask[rsv_index] = 1'b1;
  end

  // Reservation beats a same-edge write so the newest producer stays pending
  always_ff @(posedge clk) begin
    if (clr) pending <= '0;
    else     pending <= (pending & ~wr_mask) | set_mask;
  end

  always_comb begin
    rd_busy = '0;
    for (int r = 0; r < N_RD; r++) begin
      rd_busy[r] = pending[rd_index[r*ADDR_W +: ADDR_W]];
      if ((BYPASS != 0) && wr_mask[rd_index[r*ADDR_W +: ADDR_W]] &&
          !set_mask[rd_index[r*ADDR_W +: ADDR_W]])
        rd_busy[r] = 1'b0;
    end
  end
endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with write priority, same-cycle bypass and reservation scoreboard.
// Latency: writes commit on the clk edge, reads combinational; no backpressure (all ports always accepted).
module register_file_mp
  import register_file_mp_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int N_WR     = RF_N_WR,
  parameter int N_RD     = RF_N_RD,
  parameter int ZERO_REG = RF_ZERO_REG,
  parameter int BYPASS   = RF_BYPASS
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic [N_WR-1:0]        wr_en,
  input  logic [N_WR*ADDR_W-1:0] wr_index,
  input  logic [N_WR*DATA_W-1:0] wr_data,
  input  logic [N_RD*ADDR_W-1:0] rd_index,
  output logic [N_RD*DATA_W-1:0] rd_data,
  output logic [N_RD-1:0]        rd_busy,
  input  logic                   rsv_en,
  input  logic [ADDR_W-1:0]      rsv_index,
  output logic                   rsv_ok,
  output logic                   wr_conflict
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [N_WR-1:0]   wr_act;
  logic              conflict_c;

  always_comb begin
    wr_act = '0;
    for (int p = 0; p < N_WR; p++)
      wr_act[p] = wr_en[p] && !clr &&
                  !((ZERO_REG != 0) && (wr_index[p*ADDR_W +: ADDR_W] == '0));
  end

  always_comb begin
    conflict_c = 1'b0;
    for (int p = 1; p < N_WR; p++)
      for (int q = 0; q < p; q++)
        if (wr_act[p] && wr_act[q] &&
            (wr_index[p*ADDR_W +: ADDR_W] == wr_index[q*ADDR_W +: ADDR_W]))
          conflict_c = 1'b1;
  end

  // Highest port first so the lowest-numbered port's assignment lands last and wins
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_conflict <= 1'b0;
    end else begin
      for (int p = N_WR - 1; p >= 0; p--)
        if (wr_act[p]) mem[wr_index[p*ADDR_W +: ADDR_W]] <= wr_data[p*DATA_W +: DATA_W];
      wr_conflict <= conflict_c;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int r = 0; r < N_RD; r++) begin
      rd_data[r*DATA_W +: DATA_W] = mem[rd_index[r*ADDR_W +: ADDR_W]];
      if (BYPASS != 0)
        for (int p = N_WR - 1; p >= 0; p--)
          if (wr_act[p] && (wr_index[p*ADDR_W +: ADDR_W] == rd_index[r*ADDR_W +: ADDR_W]))
            rd_data[r*DATA_W +: DATA_W] = wr_data[p*DATA_W +: DATA_W];
      if ((ZERO_REG != 0) && (rd_index[r*ADDR_W +: ADDR_W] == '0))
        rd_data[r*DATA_W +: DATA_W] = '0;
    end
  end

  rf_scoreboard #(
    .ADDR_W  (ADDR_W),
    .N_WR    (N_WR),
    .N_RD    (N_RD),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) u_scoreboard (
    .clk      (clk),
    .clr      (clr),
    .wr_act   (wr_act),
    .wr_index (wr_index),
    .rsv_en   (rsv_en),
    .rsv_index(rsv_index),
    .rd_index (rd_index),
    .rsv_ok   (rsv_ok),
    .rd_busy  (rd_busy)
  );
endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp at default parameters.
module tb_register_file_mp;
  import register_file_mp_pkg::*;

  localparam int DW = RF_DATA_W;
  localparam int AW = RF_ADDR_W;

  logic                  clk = 1'b0;
  logic                  clr;
  logic [RF_N_WR-1:0]    wr_en;
  logic [RF_N_WR*AW-1:0] wr_index;
  logic [RF_N_WR*DW-1:0] wr_data;
  logic [RF_N_RD*AW-1:0] rd_index;
  logic [RF_N_RD*DW-1:0] rd_data;
  logic [RF_N_RD-1:0]    rd_busy;
  logic                  rsv_en;
  logic [AW-1:0]         rsv_index;
  logic                  rsv_ok;
  logic                  wr_conflict;

  int errors = 0;
  int checks = 0;

  register_file_mp dut (
    .clk        (clk),
    .clr        (clr),
    .wr_en      (wr_en),
    .wr_index   (wr_index),
    .wr_data    (wr_data),
    .rd_index   (rd_index),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .rsv_en     (rsv_en),
    .rsv_index  (rsv_index),
    .rsv_ok     (rsv_ok),
    .wr_conflict(wr_conflict)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Commit on the next edge, then return 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en  = '0;
    rsv_en = 1'b0;
  endtask

  task automatic set_wr(input int p, input logic [AW-1:0] idx, input logic [DW-1:0] d);
    wr_en[p]            = 1'b1;
    wr_index[p*AW +: AW] = idx;
    wr_data[p*DW +: DW]  = d;
  endtask

  task automatic set_rd(input int r, input logic [AW-1:0] idx);
    rd_index[r*AW +: AW] = idx;
  endtask

  initial begin
    clr = 1'b1; wr_en = '0; wr_index = '0; wr_data = '0;
    rd_index = '0; rsv_en = 1'b0; rsv_index = '0;
    tick(); tick();
    clr = 1'b0;
    #1;
    check_val("reset_conflict", {31'b0, wr_conflict}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      set_rd(0, AW'(i)); set_rd(1, AW'(31 - i));
      #1;
      check_val("reset_rd0", rd_data[DW-1:0], 32'd0);
      check_val("reset_rd1", rd_data[2*DW-1:DW], 32'd0);
      check_val("reset_busy", {30'b0, rd_busy}, 32'd0);
    end

    // Two distinct writes on one edge
    set_wr(0, 5'd2, 32'd20); set_wr(1, 5'd3, 32'd45);
    tick(); idle_inputs();
    set_rd(0, 5'd2); set_rd(1, 5'd3);
    #1;
    check_val("wr_reg2", rd_data[DW-1:0], 32'd20);
    check_val("wr_reg3", rd_data[2*DW-1:DW], 32'd45);
    check_val("wr_noconf", {31'b0, wr_conflict}, 32'd0);

    // Collision: port 0 wins, conflict pulses one cycle
    set_wr(0, 5'd2, 32'd35); set_wr(1, 5'd2, 32'd10);
    tick(); idle_inputs();
    #1;
    check_val("coll_reg2", rd_data[DW-1:0], 32'd35);
    check_val("coll_conf1", {31'b0, wr_conflict}, 32'd1);
    tick();
    check_val("coll_conf0", {31'b0, wr_conflict}, 32'd0);

    // Bypass from port 1
    set_rd(0, 5'd7);
    set_wr(1, 5'd7, 32'hDEADBEEF);
    #1;
    check_val("byp_rd0", rd_data[DW-1:0], 32'hDEADBEEF);
    tick(); idle_inputs();
    #1;
    check_val("byp_stored", rd_data[DW-1:0], 32'hDEADBEEF);
    // Bypass priority: port 0 data forwarded on collision
    set_wr(0, 5'd7, 32'h11111111); set_wr(1, 5'd7, 32'h22222222);
    #1;
    check_val("byp_prio", rd_data[DW-1:0], 32'h11111111);
    tick(); idle_inputs();
    #1;
    check_val("byp_prio_st", rd_data[DW-1:0], 32'h11111111);
    tick();

    // Reservation of reg 5
    check_val("rsv_off", {31'b0, rsv_ok}, 32'd0);
    rsv_en = 1'b1; rsv_index = 5'd5; set_rd(0, 5'd5);
    #1;
    check_val("rsv5_ok", {31'b0, rsv_ok}, 32'd1);
    tick(); idle_inputs();
    #1;
    check_val("rsv5_busy", {31'b0, rd_busy[0]}, 32'd1);
    rsv_en = 1'b1;
    #1;
    check_val("rsv5_again", {31'b0, rsv_ok}, 32'd0);
    tick(); idle_inputs();
    #1;
    check_val("rsv5_still", {31'b0, rd_busy[0]}, 32'd1);
    set_wr(0, 5'd5, 32'd99);
    #1;
    check_val("rsv5_bypbusy", {31'b0, rd_busy[0]}, 32'd0);
    tick(); idle_inputs();
    #1;
    check_val("rsv5_clear", {31'b0, rd_busy[0]}, 32'd0);
    check_val("rsv5_data", rd_data[DW-1:0], 32'd99);

    // Register 0 is hard-wired
    set_rd(0, 5'd0); set_wr(0, 5'd0, 32'd1);
    rsv_en = 1'b1; rsv_index = 5'd0;
    #1;
    check_val("zero_byp", rd_data[DW-1:0], 32'd0);
    check_val("zero_rsvok", {31'b0, rsv_ok}, 32'd1);
    tick(); idle_inputs();
    #1;
    check_val("zero_rd", rd_data[DW-1:0], 32'd0);
    check_val("zero_busy", {31'b0, rd_busy[0]}, 32'd0);

    // Same-edge reserve and write of reg 9
    set_rd(0, 5'd9);
    rsv_en = 1'b1; rsv_index = 5'd9; set_wr(0, 5'd9, 32'd4);
    #1;
    check_val("r9_ok", {31'b0, rsv_ok}, 32'd1);
    tick(); idle_inputs();
    #1;
    check_val("r9_busy", {31'b0, rd_busy[0]}, 32'd1);
    check_val("r9_data", rd_data[DW-1:0], 32'd4);

    // Reset while pending; writes and bypass suppressed during clr
    clr = 1'b1;
    set_wr(1, 5'd11, 32'd55); set_rd(1, 5'd11);
    #1;
    check_val("clr_holds", rd_data[DW-1:0], 32'd4);
    check_val("clr_nobyp", rd_data[2*DW-1:DW], 32'd0);
    tick();
    clr = 1'b0; idle_inputs();
    #1;
    check_val("clr_r9", rd_data[DW-1:0], 32'd0);
    check_val("clr_busy", {31'b0, rd_busy[0]}, 32'd0);
    check_val("clr_r11", rd_data[2*DW-1:DW], 32'd0);
    set_rd(1, 5'd5);
    #1;
    check_val("clr_r5", rd_data[2*DW-1:DW], 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/register_file_mp.md
REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DATA_W, 32, register width in bits
- ADDR_W, 5, index width; depth = 2**ADDR_W
- N_WR, 2, write ports
- N_RD, 2, read ports
- ZERO_REG, 1, when 1 register 0 reads 0 and ignores writes/reservations
- BYPASS, 1, when 1 reads forward same-cycle write data
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock, all state updates on rising edge
- clr  in  1  reset, synchronous, active-high
- wr_en  in  N_WR  per-port write enable
- wr_index  in  N_WR*ADDR_W  packed write indices, port p at bits [p*ADDR_W +: ADDR_W]
- wr_data  in  N_WR*DATA_W  packed write data, same packing
- rd_index  in  N_RD*ADDR_W  packed read indices
- rd_data  out  N_RD*DATA_W  packed read data
- rd_busy  out  N_RD  read register has an outstanding reservation
- rsv_en  in  1  reserve request: mark rsv_index pending
- rsv_index  in  ADDR_W  register to reserve
- rsv_ok  out  1  combinational; 1 when rsv_en and target not pending (or pending and written this cycle)
- wr_conflict  out  1  registered one-cycle pulse: two or more enabled write ports hit the same index

Function
REQ-003 Writes SHALL commit on the rising clk edge; the new value is visible on rd_data combinationally in the cycle after the edge.
REQ-004 When several enabled write ports target the same index, the lowest-numbered port SHALL win; the others are dropped for that index.
REQ-005 wr_conflict SHALL be 1 in the cycle after any REQ-004 collision, else 0.
REQ-006 Reads SHALL be combinational; with BYPASS=1 a read whose index matches an enabled write port in the same cycle SHALL return that write's data, applying the REQ-004 priority.
REQ-007 With ZERO_REG=1, reads of index 0 SHALL return 0 and writes, bypass and reservations to index 0 SHALL be ignored (rsv_ok=1, no pending bit set).
REQ-008 A per-register pending bit SHALL be set on the edge where rsv_en and rsv_ok are both 1; a rejected reservation (rsv_ok=0) SHALL change no state.
REQ-009 A committed write SHALL clear the target's pending bit on the same edge.
REQ-010 Reservation and write to the same index on the same edge SHALL leave the bit set (new producer wins) and commit the data.
REQ-011 rd_busy[p] SHALL reflect the pending bit of rd_index[p]; with BYPASS=1 it SHALL read 0 if that index is being written this cycle, unless the same index is also being reserved this cycle.
REQ-012 rsv_ok SHALL be 0 when rsv_en=0.

Reset
REQ-013 On a rising clk edge with clr=1, all registers SHALL become 0, all pending bits 0 and wr_conflict 0; all writes and reservations in that cycle SHALL be ignored.
REQ-014 While clr=1, rd_data SHALL still reflect stored contents (bypass disabled), so all reads return 0 from the second clr cycle on.
REQ-015 Reset asserted while registers are pending SHALL clear them with no further effect.

Structure
REQ-016 Default widths, depth and port counts SHALL live in a shared parameter package or include file used by this block and its bench.
REQ-017 The pending-bit array, rsv_ok and rd_busy logic SHALL be a sub-module rf_scoreboard; storage, priority and bypass SHALL stay in register_file_mp.

Verification
REQ-018 The bench SHALL cover these directed scenarios with default parameters:
- Reset for 2 cycles, then read indices 0..31 -> all 0, rd_busy=0, wr_conflict=0.
- Port0 writes 20 to reg 2, port1 writes 45 to reg 3 on one edge -> next cycle reg2=20, reg3=45, wr_conflict=0.
- Port0 writes 35 and port1 writes 10 to reg 2 on one edge -> reg2=35, wr_conflict=1 for exactly one cycle.
- BYPASS: port1 writes 0xDEADBEEF to reg 7 while rd_index0=7 -> rd_data0=0xDEADBEEF in the same cycle.
- Reserve reg 5 -> rsv_ok=1, rd_busy=1 next cycle; re-reserve -> rsv_ok=0; write 99 to reg 5 -> rd_busy=0, reg5=99; write reg 0 with 1 -> reads 0.
- Reserve reg 9 and write 4 to it on the same edge -> rd_busy stays 1, reg9=4; then clr -> reg9=0, rd_busy=0.
